sram_pingpong: RTL and testbench
================================

Name: sram_pingpong

Overview:
Multi-channel, double-buffered on-chip SRAM for LeNet feature-map and weight staging between accelerator layers. Each channel holds two banks (ping/pong) of SIZE words. A producer layer fills the write bank while a consumer layer reads the other bank; a one-cycle swap exchanges their roles. Adds per-channel read-valid tracking, selectable read latency, out-of-range protection and synchronous reset of all control/output state.

Parameters:
DATA_WIDTH, 8, bits per word per channel
ADDR_WIDTH, 8, address bits per channel
CHANNEL, 1, number of independent channels
SIZE, 256, words per bank per channel (SIZE <= 2**ADDR_WIDTH)
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
swap  input  1  single-cycle pulse: exchange read/write banks for all channels
bank_sel  output  1  current write bank (0 = ping written, pong read; 1 = reverse)
wr_en  input  CHANNEL  per-channel write enable
wr_addr  input  ADDR_WIDTH*CHANNEL  per-channel write address
wr_data  input  DATA_WIDTH*CHANNEL  per-channel write data
rd_en  input  CHANNEL  per-channel read enable
rd_addr  input  ADDR_WIDTH*CHANNEL  per-channel read address
rd_data  output  DATA_WIDTH*CHANNEL  per-channel read data
rd_valid  output  CHANNEL  per-channel read data valid, one-cycle pulse per accepted read
Bus packing (all vector ports): (MSB)[channel n-1 ... channel 1, channel 0](LSB); channel i occupies slice [(i+1)*W-1 : i*W].

Behaviour:
- Reset (rst=1 at posedge): bank_sel=0, rd_data=0, rd_valid=0, every internal latency-pipeline stage cleared. Memory contents are NOT reset. Reads/writes presented during a reset cycle are dropped. A read in flight when reset asserts produces no rd_valid.
- Write: at posedge with wr_en[i]=1, word written to channel i, bank bank_sel, address wr_addr slice. Channels independent.
- Read: at posedge with rd_en[i]=1, channel i reads bank ~bank_sel at rd_addr slice. Bank chosen is the one current at issue cycle; a later swap does not affect an in-flight read.
- Latency: RD_LATENCY=1 -> rd_data[i]/rd_valid[i] updated at the edge that accepts the read (visible in the next cycle). RD_LATENCY=2 -> one additional output register stage; data/valid appear one cycle later. Back-to-back reads every cycle sustained at full throughput for both latencies.
- rd_valid[i] high exactly one cycle per accepted read; otherwise 0. rd_data[i] holds its last value when no new read completes.
- swap: at posedge with swap=1, bank_sel toggles. Writes and reads issued in that same cycle use the pre-toggle bank assignment. swap held high N cycles toggles N times.
- Read and write always target opposite banks, so no same-bank collision; same-address read/write in one cycle is legal, read returns the other bank's stored word.
- Out of range: wr_addr >= SIZE -> write ignored, no memory change. rd_addr >= SIZE -> read accepted, rd_valid pulses, rd_data slice = 0.
- Channels fully independent; no cross-channel ordering.
- Parameter check: RD_LATENCY not 1 or 2 is a elaboration error.

Test Plan:
- Reset: drive rst=1 two cycles with rd_en=all-ones -> bank_sel=0, rd_data=0, rd_valid=0 throughout and one cycle after rst deasserts.
- Ping-pong: CHANNEL=2; write ch0 addr 5 = 0xA5, ch1 addr 5 = 0x3C (bank 0); pulse swap; read addr 5 both channels -> with RD_LATENCY=1, rd_data=0x3CA5 and rd_valid=2'b11 one cycle after issue; with RD_LATENCY=2, two cycles after.
- Swap in same cycle as write/read: write 0x11 to addr 0 with swap=1 -> lands in bank 0; read addr 0 issued same cycle returns bank 1 content; after swap, read addr 0 returns 0x11.
- Streaming: read addresses 0..15 every cycle from a pre-filled bank (value = addr+0x40) -> 16 consecutive rd_valid pulses, data 0x40..0x4F in order, no bubbles.
- Out of range: SIZE=200; write 0xFF to addr 210, then read addr 210 -> rd_valid=1, rd_data=0; addr 199 write/read after swap returns written value.
- Reset mid-read: RD_LATENCY=2, issue read then assert rst next cycle -> no rd_valid pulse, rd_data=0.

Source files
------------

// File: rtl/sram_pingpong.sv
// Multi-channel double-buffered (ping/pong) SRAM. Producers write bank_sel and
// consumers read the other bank; a swap pulse exchanges the two roles.
module sram_pingpong #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CHANNEL    = 1,
    parameter int unsigned SIZE       = 256,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             swap,
    output logic                             bank_sel,
    input  logic [CHANNEL-1:0]               wr_en,
    input  logic [ADDR_WIDTH*CHANNEL-1:0]    wr_addr,
    input  logic [DATA_WIDTH*CHANNEL-1:0]    wr_data,
    input  logic [CHANNEL-1:0]               rd_en,
    input  logic [ADDR_WIDTH*CHANNEL-1:0]    rd_addr,
    output logic [DATA_WIDTH*CHANNEL-1:0]    rd_data,
    output logic [CHANNEL-1:0]               rd_valid
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [AW:0] SIZE_W = (AW + 1)'(SIZE);

    // Elaboration-time parameter legality
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("sram_pingpong: RD_LATENCY must be 1 or 2");
    end
    if ((SIZE == 0) || (SIZE > (2 ** AW))) begin : g_bad_size
        $error("sram_pingpong: SIZE must be in 1..2**ADDR_WIDTH");
    end

    // Write-bank pointer; the read bank is always its complement
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel <= 1'b0;
        end else if (swap) begin
            bank_sel <= ~bank_sel;
        end
    end

    for (genvar i = 0; i < CHANNEL; i++) begin : g_ch
        logic [DW-1:0] mem_ping [SIZE];
        logic [DW-1:0] mem_pong [SIZE];

        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [DW-1:0] wd;
        logic [IW-1:0] widx;
        logic [IW-1:0] ridx;
        logic          wr_ok_c;
        logic          rd_in_range_c;
        logic [DW-1:0] rd_word_c;

        logic          s1_valid;
        logic [DW-1:0] s1_data;

        assign wa = wr_addr[i*AW +: AW];
        assign ra = rd_addr[i*AW +: AW];
        assign wd = wr_data[i*DW +: DW];

        // Index truncation is safe: only used when the address is below SIZE
        assign widx = wa[IW-1:0];
        assign ridx = ra[IW-1:0];

        assign wr_ok_c       = wr_en[i] && ({1'b0, wa} < SIZE_W);
        assign rd_in_range_c = {1'b0, ra} < SIZE_W;

        // Writes go to bank_sel; dropped while in reset
        always_ff @(posedge clk) begin
            if (!rst && wr_ok_c) begin
                if (bank_sel) begin
                    mem_pong[widx] <= wd;
                end else begin
                    mem_ping[widx] <= wd;
                end
            end
        end

        // Read bank is ~bank_sel, sampled at issue so a later swap cannot disturb it
        always_comb begin
            rd_word_c = '0;
            if (rd_in_range_c) begin
                rd_word_c = bank_sel ? mem_ping[ridx] : mem_pong[ridx];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= rd_en[i];
                if (rd_en[i]) begin
                    s1_data <= rd_word_c;
                end
            end
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic          s2_valid;
            logic [DW-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_data[i*DW +: DW] = s2_data;
            assign rd_valid[i]         = s2_valid;
        end else begin : g_lat1
            assign rd_data[i*DW +: DW] = s1_data;
            assign rd_valid[i]         = s1_valid;
        end
    end

endmodule

// File: tb/tb_sram_pingpong.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus
// stream, each checked against hand-computed expectations.
module tb_sram_pingpong;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned CH = 2;
    localparam int unsigned SZ = 200;

    logic              clk;
    logic              rst;
    logic              swap;
    logic [CH-1:0]     wr_en;
    logic [AW*CH-1:0]  wr_addr;
    logic [DW*CH-1:0]  wr_data;
    logic [CH-1:0]     rd_en;
    logic [AW*CH-1:0]  rd_addr;

    logic              bank_sel1;
    logic [DW*CH-1:0]  rd_data1;
    logic [CH-1:0]     rd_valid1;
    logic              bank_sel2;
    logic [DW*CH-1:0]  rd_data2;
    logic [CH-1:0]     rd_valid2;

    int total;
    int bad;

    sram_pingpong #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNEL(CH), .SIZE(SZ), .RD_LATENCY(1)
    ) u_lat1 (
        .clk(clk), .rst(rst), .swap(swap), .bank_sel(bank_sel1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    sram_pingpong #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNEL(CH), .SIZE(SZ), .RD_LATENCY(2)
    ) u_lat2 (
        .clk(clk), .rst(rst), .swap(swap), .bank_sel(bank_sel2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rd_en = 2'b11;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst   = 1'b0;
                rd_en = 2'b00;
            end
            step();
            total++;
            if ({bank_sel1, rd_valid1, rd_data1} !== 19'h0) begin
                bad++;
                $display("FAIL reset_lat1 cyc%0d: got %h want %h", c, {bank_sel1, rd_valid1, rd_data1}, 19'h0);
            end
            total++;
            if ({bank_sel2, rd_valid2, rd_data2} !== 19'h0) begin
                bad++;
                $display("FAIL reset_lat2 cyc%0d: got %h want %h", c, {bank_sel2, rd_valid2, rd_data2}, 19'h0);
            end
        end
    endtask

    task automatic test_swap_hold();
        logic exp_bs;
        exp_bs = 1'b0;
        swap = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) swap = 1'b0;
            else        exp_bs = ~exp_bs;
            step();
            total++;
            if ({bank_sel1, bank_sel2} !== {exp_bs, exp_bs}) begin
                bad++;
                $display("FAIL swap_hold cyc%0d: got %b want %b", c, {bank_sel1, bank_sel2}, {exp_bs, exp_bs});
            end
        end
    endtask

    task automatic test_pingpong();
        wr_en = 2'b11; wr_addr = {8'd5, 8'd5}; wr_data = {8'h3C, 8'hA5};
        step();
        wr_en = 2'b00; swap = 1'b1;
        step();
        swap = 1'b0;
        total++;
        if ({bank_sel1, bank_sel2} !== 2'b11) begin
            bad++;
            $display("FAIL pp_bank_sel: got %b want %b", {bank_sel1, bank_sel2}, 2'b11);
        end
        rd_en = 2'b11; rd_addr = {8'd5, 8'd5};
        step();
        rd_en = 2'b00;
        total++;
        if ({rd_valid1, rd_data1} !== {2'b11, 16'h3CA5}) begin
            bad++;
            $display("FAIL pp_lat1: got %h want %h", {rd_valid1, rd_data1}, {2'b11, 16'h3CA5});
        end
        total++;
        if (rd_valid2 !== 2'b00) begin
            bad++;
            $display("FAIL pp_lat2_early: got %b want %b", rd_valid2, 2'b00);
        end
        step();
        total++;
        if ({rd_valid1, rd_data1} !== {2'b00, 16'h3CA5}) begin
            bad++;
            $display("FAIL pp_lat1_hold: got %h want %h", {rd_valid1, rd_data1}, {2'b00, 16'h3CA5});
        end
        total++;
        if ({rd_valid2, rd_data2} !== {2'b11, 16'h3CA5}) begin
            bad++;
            $display("FAIL pp_lat2: got %h want %h", {rd_valid2, rd_data2}, {2'b11, 16'h3CA5});
        end
        step();
        total++;
        if ({rd_valid2, rd_data2} !== {2'b00, 16'h3CA5}) begin
            bad++;
            $display("FAIL pp_lat2_hold: got %h want %h", {rd_valid2, rd_data2}, {2'b00, 16'h3CA5});
        end
    endtask

    task automatic test_swap_same_cycle();
        // bank_sel=1: seed bank 1 addr 0, then swap back to bank_sel=0
        wr_en = 2'b11; wr_addr = {8'd0, 8'd0}; wr_data = {8'h78, 8'h77};
        step();
        wr_en = 2'b00; swap = 1'b1;
        step();
        wr_en = 2'b11; wr_data = {8'h22, 8'h11};
        rd_en = 2'b11; rd_addr = {8'd0, 8'd0};
        step();
        wr_en = 2'b00; rd_en = 2'b00; swap = 1'b0;
        total++;
        if ({bank_sel1, rd_valid1, rd_data1} !== {1'b1, 2'b11, 16'h7877}) begin
            bad++;
            $display("FAIL swap_same_lat1: got %h want %h", {bank_sel1, rd_valid1, rd_data1}, {1'b1, 2'b11, 16'h7877});
        end
        step();
        total++;
        if ({rd_valid2, rd_data2} !== {2'b11, 16'h7877}) begin
            bad++;
            $display("FAIL swap_same_lat2: got %h want %h", {rd_valid2, rd_data2}, {2'b11, 16'h7877});
        end
        rd_en = 2'b11;
        step();
        rd_en = 2'b00;
        total++;
        if ({rd_valid1, rd_data1} !== {2'b11, 16'h2211}) begin
            bad++;
            $display("FAIL swap_after_lat1: got %h want %h", {rd_valid1, rd_data1}, {2'b11, 16'h2211});
        end
        step();
        total++;
        if ({rd_valid2, rd_data2} !== {2'b11, 16'h2211}) begin
            bad++;
            $display("FAIL swap_after_lat2: got %h want %h", {rd_valid2, rd_data2}, {2'b11, 16'h2211});
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        // bank_sel=1: fill bank 1 addresses 0..15, then swap to read it
        for (int a = 0; a < 16; a++) begin
            wr_en = 2'b11; wr_addr = {8'(a), 8'(a)}; wr_data = {8'(a + 'h80), 8'(a + 'h40)};
            step();
        end
        wr_en = 2'b00; swap = 1'b1;
        step();
        swap = 1'b0;
        for (int k = 0; k < 18; k++) begin
            rd_en   = (k < 16) ? 2'b11 : 2'b00;
            rd_addr = {8'(k), 8'(k)};
            step();
            e = (k < 16) ? {2'b11, 8'(k + 'h80), 8'(k + 'h40)} : {2'b00, 16'h8F4F};
            total++;
            if ({rd_valid1, rd_data1} !== e) begin
                bad++;
                $display("FAIL stream_lat1 k%0d: got %h want %h", k, {rd_valid1, rd_data1}, e);
            end
            total++;
            if (k >= 1 && k <= 16) begin
                e = {2'b11, 8'(k - 1 + 'h80), 8'(k - 1 + 'h40)};
                if ({rd_valid2, rd_data2} !== e) begin
                    bad++;
                    $display("FAIL stream_lat2 k%0d: got %h want %h", k, {rd_valid2, rd_data2}, e);
                end
            end else if (rd_valid2 !== 2'b00) begin
                bad++;
                $display("FAIL stream_lat2_idle k%0d: got %b want %b", k, rd_valid2, 2'b00);
            end
        end
        rd_en = 2'b00;
    endtask

    task automatic test_out_of_range();
        logic [15:0] addrs [4];
        logic [15:0] exp_d [4];
        logic [17:0] e;
        addrs[0] = {8'd199, 8'd199}; exp_d[0] = 16'h9A99;
        addrs[1] = {8'd210, 8'd210}; exp_d[1] = 16'h0000;
        addrs[2] = {8'd200, 8'd200}; exp_d[2] = 16'h0000;
        addrs[3] = {8'd210, 8'd199}; exp_d[3] = 16'h0099;
        // bank_sel=0 here: writes land in bank 0
        wr_en = 2'b11; wr_addr = {8'd210, 8'd210}; wr_data = 16'hFFFF;
        step();
        wr_addr = {8'd199, 8'd199}; wr_data = {8'h9A, 8'h99};
        step();
        wr_addr = {8'd200, 8'd200}; wr_data = 16'hEEEE;
        step();
        wr_en = 2'b00; swap = 1'b1;
        step();
        swap = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_en   = (k < 4) ? 2'b11 : 2'b00;
            rd_addr = (k < 4) ? addrs[k] : 16'h0;
            step();
            e = (k < 4) ? {2'b11, exp_d[k]} : {2'b00, exp_d[3]};
            total++;
            if ({rd_valid1, rd_data1} !== e) begin
                bad++;
                $display("FAIL oor_lat1 k%0d: got %h want %h", k, {rd_valid1, rd_data1}, e);
            end
            total++;
            if (k >= 1) begin
                e = {2'b11, exp_d[k-1]};
                if ({rd_valid2, rd_data2} !== e) begin
                    bad++;
                    $display("FAIL oor_lat2 k%0d: got %h want %h", k, {rd_valid2, rd_data2}, e);
                end
            end else if (rd_valid2 !== 2'b00) begin
                bad++;
                $display("FAIL oor_lat2_idle k%0d: got %b want %b", k, rd_valid2, 2'b00);
            end
        end
        rd_en = 2'b00;
    endtask

    task automatic test_reset_mid_read();
        // bank_sel=1: reads bank 0 where addr 199 holds 0x9A99
        rd_en = 2'b11; rd_addr = {8'd199, 8'd199};
        step();
        rd_en = 2'b00; rst = 1'b1;
        wr_en = 2'b11; wr_addr = {8'd0, 8'd0}; wr_data = 16'hEEEE;
        total++;
        if ({rd_valid1, rd_data1} !== {2'b11, 16'h9A99}) begin
            bad++;
            $display("FAIL rmr_issue_lat1: got %h want %h", {rd_valid1, rd_data1}, {2'b11, 16'h9A99});
        end
        step();
        rst = 1'b0; wr_en = 2'b00;
        total++;
        if ({bank_sel2, rd_valid2, rd_data2} !== 19'h0) begin
            bad++;
            $display("FAIL rmr_lat2: got %h want %h", {bank_sel2, rd_valid2, rd_data2}, 19'h0);
        end
        total++;
        if ({bank_sel1, rd_valid1, rd_data1} !== 19'h0) begin
            bad++;
            $display("FAIL rmr_lat1: got %h want %h", {bank_sel1, rd_valid1, rd_data1}, 19'h0);
        end
        step();
        total++;
        if ({rd_valid2, rd_data2} !== 18'h0) begin
            bad++;
            $display("FAIL rmr_lat2_after: got %h want %h", {rd_valid2, rd_data2}, 18'h0);
        end
        // Write during reset must have been dropped: bank 1 addr 0 keeps 0x8040
        rd_en = 2'b11; rd_addr = {8'd0, 8'd0};
        step();
        rd_en = 2'b00;
        total++;
        if ({rd_valid1, rd_data1} !== {2'b11, 16'h8040}) begin
            bad++;
            $display("FAIL rst_wr_drop_lat1: got %h want %h", {rd_valid1, rd_data1}, {2'b11, 16'h8040});
        end
        step();
        total++;
        if ({rd_valid2, rd_data2} !== {2'b11, 16'h8040}) begin
            bad++;
            $display("FAIL rst_wr_drop_lat2: got %h want %h", {rd_valid2, rd_data2}, {2'b11, 16'h8040});
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        swap    = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        test_reset();
        test_swap_hold();
        test_pingpong();
        test_swap_same_cycle();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
